// File: rtl/univ_reg.sv
// Universal WIDTH-bit register: hold, load, shift, rotate and optional count, with carry and zero flags.
// Define UNIV_REG_COUNT_EN to enable increment/decrement; otherwise modes 110/111 act as hold.
module univ_reg #(
   parameter int unsigned          WIDTH     = 8,
   parameter logic [WIDTH-1:0]     RESET_VAL = {WIDTH{1'b0}}
) (
   input  logic             Clk,
   input  logic             Rst_n,
   input  logic             En,
   input  logic [2:0]       Mode,
   input  logic [WIDTH-1:0] D,
   input  logic             Sin,
   output logic [WIDTH-1:0] Q,
   output logic [WIDTH-1:0] Qn,
   output logic             Co,
   output logic             Zero
);

   typedef enum logic [2:0] {
      MODE_HOLD = 3'b000,
      MODE_LOAD = 3'b001,
      MODE_SHL  = 3'b010,
      MODE_SHR  = 3'b011,
      MODE_ROL  = 3'b100,
      MODE_ROR  = 3'b101,
      MODE_INC  = 3'b110,
      MODE_DEC  = 3'b111
   } mode_e;

   logic [WIDTH-1:0] q_q;
   logic [WIDTH-1:0] q_d;
   logic             co_q;
   logic             co_d;
   mode_e            mode_s;

`ifdef UNIV_REG_COUNT_EN
   // Carry/borrow is bit WIDTH of a WIDTH+1-bit sum or difference.
   logic [WIDTH:0]   inc_s;
   logic [WIDTH:0]   dec_s;

   // Counting datapath, shared by both count modes.
   always_comb begin
      inc_s = {1'b0, q_q} + {{WIDTH{1'b0}}, 1'b1};
      dec_s = {1'b0, q_q} - {{WIDTH{1'b0}}, 1'b1};
   end
`endif

   assign mode_s = mode_e'(Mode);

   // Next-state selection by mode; any unhandled mode holds.
   always_comb begin
      q_d  = q_q;
      co_d = co_q;
      if (En) begin
         case (mode_s)
            MODE_HOLD: begin
               q_d  = q_q;
               co_d = co_q;
            end
            MODE_LOAD: begin
               q_d  = D;
               co_d = 1'b0;
            end
            MODE_SHL: begin
               q_d  = {q_q[WIDTH-2:0], Sin};
               co_d = q_q[WIDTH-1];
            end
            MODE_SHR: begin
               q_d  = {Sin, q_q[WIDTH-1:1]};
               co_d = q_q[0];
            end
            MODE_ROL: begin
               q_d  = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
               co_d = q_q[WIDTH-1];
            end
            MODE_ROR: begin
               q_d  = {q_q[0], q_q[WIDTH-1:1]};
               co_d = q_q[0];
            end
`ifdef UNIV_REG_COUNT_EN
            MODE_INC: begin
               q_d  = inc_s[WIDTH-1:0];
               co_d = inc_s[WIDTH];
            end
            MODE_DEC: begin
               q_d  = dec_s[WIDTH-1:0];
               co_d = dec_s[WIDTH];
            end
`endif
            default: begin
               q_d  = q_q;
               co_d = co_q;
            end
         endcase
      end else begin
         q_d  = q_q;
         co_d = co_q;
      end
   end

   // State register with asynchronous reset to RESET_VAL.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         q_q  <= RESET_VAL;
         co_q <= 1'b0;
      end else begin
         q_q  <= q_d;
         co_q <= co_d;
      end
   end

   assign Q    = q_q;
   assign Co   = co_q;
   assign Qn   = ~q_q;
   assign Zero = (q_q == {WIDTH{1'b0}});

endmodule

// File: tb/tb_univ_reg.sv
// Directed self-checking bench for univ_reg (WIDTH=8, RESET_VAL=8'hA5).
module tb_univ_reg;

`ifdef UNIV_REG_COUNT_EN
   localparam logic CNT = 1'b1;
`else
   localparam logic CNT = 1'b0;
`endif

   logic       Clk;
   logic       Rst_n;
   logic       En;
   logic [2:0] Mode;
   logic [7:0] D;
   logic       Sin;
   logic [7:0] Q;
   logic [7:0] Qn;
   logic       Co;
   logic       Zero;

   int n_checks;
   int n_pass;
   int n_fail;

   univ_reg #(.WIDTH(8), .RESET_VAL(8'hA5)) dut (
      .Clk  (Clk),
      .Rst_n(Rst_n),
      .En   (En),
      .Mode (Mode),
      .D    (D),
      .Sin  (Sin),
      .Q    (Q),
      .Qn   (Qn),
      .Co   (Co),
      .Zero (Zero)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   task automatic op(input logic [2:0] m, input logic [7:0] d, input logic s);
      En   = 1'b1;
      Mode = m;
      D    = d;
      Sin  = s;
      step();
   endtask

   initial begin
      n_checks = 0;
      n_pass   = 0;
      n_fail   = 0;
      Rst_n = 1'b1;
      En    = 1'b0;
      Mode  = 3'b000;
      D     = 8'h00;
      Sin   = 1'b0;

      // asynchronous reset, mid-cycle, no clock edge involved
      step();
      #2 Rst_n = 1'b0;
      #1;
      chk("rst_q",    Q,           8'hA5);
      chk("rst_qn",   Qn,          8'h5A);
      chk("rst_co",   {7'd0, Co},  8'h00);
      chk("rst_zero", {7'd0, Zero}, 8'h00);
      step();
      chk("rst_hold_edge", Q, 8'hA5);
      Rst_n = 1'b1;

      op(3'b001, 8'h00, 1'b0);
      chk("load0_q",    Q,            8'h00);
      chk("load0_zero", {7'd0, Zero}, 8'h01);
      chk("load0_qn",   Qn,           8'hFF);

      // shifts
      op(3'b001, 8'h81, 1'b0);
      op(3'b010, 8'h00, 1'b0);
      chk("shl_q",  Q,          8'h02);
      chk("shl_co", {7'd0, Co}, 8'h01);
      op(3'b011, 8'h00, 1'b1);
      chk("shr_q",  Q,          8'h81);
      chk("shr_co", {7'd0, Co}, 8'h00);

      // rotates
      op(3'b101, 8'h00, 1'b0);
      chk("ror_q",  Q,          8'hC0);
      chk("ror_co", {7'd0, Co}, 8'h01);
      for (int i = 0; i < 7; i++) op(3'b101, 8'h00, 1'b0);
      chk("ror8_q",  Q,          8'h81);
      chk("ror8_co", {7'd0, Co}, 8'h01);
      op(3'b001, 8'h40, 1'b0);
      op(3'b100, 8'h00, 1'b0);
      chk("rol_q",  Q,          8'h80);
      chk("rol_co", {7'd0, Co}, 8'h00);
      op(3'b100, 8'h00, 1'b0);
      chk("rol2_q",  Q,          8'h01);
      chk("rol2_co", {7'd0, Co}, 8'h01);

      // counting (or hold when counting is compiled out)
      op(3'b001, 8'hFF, 1'b0);
      op(3'b110, 8'h00, 1'b0);
      chk("inc_wrap_q",    Q,            CNT ? 8'h00 : 8'hFF);
      chk("inc_wrap_co",   {7'd0, Co},   CNT ? 8'h01 : 8'h00);
      chk("inc_wrap_zero", {7'd0, Zero}, CNT ? 8'h01 : 8'h00);
      op(3'b110, 8'h00, 1'b0);
      chk("inc_q",  Q,          CNT ? 8'h01 : 8'hFF);
      chk("inc_co", {7'd0, Co}, 8'h00);
      op(3'b111, 8'h00, 1'b0);
      op(3'b111, 8'h00, 1'b0);
      chk("dec_wrap_q",  Q,          8'hFF);
      chk("dec_wrap_co", {7'd0, Co}, CNT ? 8'h01 : 8'h00);
      op(3'b111, 8'h00, 1'b0);
      chk("dec_q",  Q,          CNT ? 8'hFE : 8'hFF);
      chk("dec_co", {7'd0, Co}, 8'h00);

      // 3C with Co=1, then three count-up edges
      op(3'b001, 8'h9E, 1'b0);
      op(3'b010, 8'h00, 1'b0);
      chk("pre_cnt_q",  Q,          8'h3C);
      chk("pre_cnt_co", {7'd0, Co}, 8'h01);
      for (int i = 0; i < 3; i++) op(3'b110, 8'h00, 1'b0);
      chk("cnt3_q",  Q,          CNT ? 8'h3F : 8'h3C);
      chk("cnt3_co", {7'd0, Co}, CNT ? 8'h00 : 8'h01);

      // mode 000 holds, then enable gating
      op(3'b001, 8'h5A, 1'b0);
      op(3'b010, 8'h00, 1'b1);
      op(3'b000, 8'h77, 1'b0);
      chk("hold_q",  Q,          8'hB5);
      chk("hold_co", {7'd0, Co}, 8'h00);
      En = 1'b0; Mode = 3'b001; D = 8'h77; Sin = 1'b1;
      step();
      chk("en0_q",  Q,          8'hB5);
      chk("en0_co", {7'd0, Co}, 8'h00);

      // edge-triggered: no change between edges
      En = 1'b1; Mode = 3'b001; D = 8'h11;
      #2;
      chk("between_edges", Q, 8'hB5);
      D = 8'h22;
      step();
      chk("edge_load", Q, 8'h22);

      // reset in the middle of counting
      op(3'b001, 8'h10, 1'b0);
      op(3'b110, 8'h00, 1'b0);
      chk("midcnt_q", Q, CNT ? 8'h11 : 8'h10);
      #2 Rst_n = 1'b0;
      #1;
      chk("midrst_q",  Q,          8'hA5);
      chk("midrst_co", {7'd0, Co}, 8'h00);
      step();
      chk("midrst_edge_q", Q, 8'hA5);
      #2 Rst_n = 1'b1;
      step();
      chk("resume_q",  Q,          CNT ? 8'hA6 : 8'hA5);
      chk("resume_co", {7'd0, Co}, 8'h00);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/univ_reg.md
# univ_reg

Parametrised universal register: the clocked, multi-bit successor to the single-bit gated D latch. It holds WIDTH bits, updated on the rising clock edge when enabled, in one of eight modes: hold, parallel load, logical shift, rotate, and increment/decrement. It also provides complementary outputs and carry/zero flags. The datapath uses it for the accumulator, shift and program-counter style registers of the simple CPU.

## Interface
Parameters:
- WIDTH, 8: register width in bits; legal values are 2 or more.
- RESET_VAL, 0: value loaded into Q on reset; truncated to WIDTH bits.

Ports:
- Clk  input  1  clock; all state changes on the rising edge.
- Rst_n  input  1  asynchronous active-low reset.
- En  input  1  update enable; 0 means hold regardless of Mode.
- Mode  input  3  operation select (see Operation).
- D  input  WIDTH  parallel load data.
- Sin  input  1  serial input for shifts.
- Q  output  WIDTH  register contents.
- Qn  output  WIDTH  bitwise complement of Q, combinational.
- Co  output  1  registered carry/shift-out flag.
- Zero  output  1  combinational; 1 when Q == 0.

## Operation
- The clock is Clk. Reset is Rst_n: one clock, reset asynchronous and active-low.
- State: Q (WIDTH bits) and Co (1 bit). No other state.
- En=0: Q and Co hold.
- En=1 selects the update by Mode:
  - 000 hold: Q and Co unchanged.
  - 001 load: Q<=D; Co<=0.
  - 010 shift left: Q<={Q[WIDTH-2:0],Sin}; Co<=Q[WIDTH-1].
  - 011 shift right: Q<={Sin,Q[WIDTH-1:1]}; Co<=Q[0].
  - 100 rotate left: Q<={Q[WIDTH-2:0],Q[WIDTH-1]}; Co<=Q[WIDTH-1].
  - 101 rotate right: Q<={Q[0],Q[WIDTH-1:1]}; Co<=Q[0].
  - 110 increment: Q<=Q+1 modulo 2^WIDTH; Co<=1 only when Q was all-ones (wrap to 0), else 0.
  - 111 decrement: Q<=Q-1 modulo 2^WIDTH; Co<=1 only when Q was 0 (wrap to all-ones), else 0.
- Arithmetic is unsigned, WIDTH bits. Carry is taken as bit WIDTH of a WIDTH+1-bit sum; no overflow beyond Co.
- Qn=~Q and Zero=(Q==0) at all times, including during reset.

## Timing
- Latency: one cycle. A mode sampled at edge k is visible on Q and Co after edge k. Qn and Zero follow Q combinationally in the same cycle.
- Reset: Rst_n low forces Q=RESET_VAL and Co=0 immediately, independent of Clk. It then holds Q=RESET_VAL, Qn=~RESET_VAL, Co=0 and Zero=(RESET_VAL==0).
- Reset release: the first update occurs at the first rising Clk edge where Rst_n is high.
- Reset mid-operation: a count or shift in progress is discarded. No partial update survives.
- Back-to-back operations: any mode may follow any mode on consecutive edges with no bubble.
- Wrap-around:
  - increment from all-ones gives 0 with Co=1;
  - decrement from 0 gives all-ones with Co=1;
  - the next non-wrapping count clears Co.
- Inputs D, Sin and Mode need only be stable around the Clk edge. Changes between edges have no effect on Q; the block is edge-triggered, not transparent.

## Configuration
- UNIV_REG_COUNT_EN defined: modes 110 and 111 increment and decrement as specified, and the adder/subtractor is present.
- Not defined: modes 110 and 111 behave exactly as hold (Q and Co unchanged), and no adder is synthesised. All other modes, flags and reset behaviour are identical.

## Test plan
- Reset and load: assert Rst_n=0 mid-cycle with RESET_VAL=8'hA5 -> Q=A5, Qn=5A, Co=0 immediately, with no clock. Release, then load D=8'h00 -> Q=00, Zero=1.
- Shift: Q=8'b1000_0001, Sin=0, shift left -> Q=02, Co=1. Then shift right with Sin=1 -> Q=81, Co=0.
- Rotate: Q=8'h81, rotate right -> Q=C0, Co=1. Then repeat 7 more times -> Q=81.
- Counting with UNIV_REG_COUNT_EN: load FF, increment -> Q=00, Co=1, Zero=1. Increment again -> Q=01, Co=0. Decrement twice -> Q=FF, Co=1.
- Counting without UNIV_REG_COUNT_EN: Q=3C, Mode=110 for 3 edges -> Q=3C, Co unchanged.
- Enable gating and mid-count reset: En=0 with Mode=001, D=77 -> Q unchanged. Counting at Q=10, pull Rst_n low between edges -> Q=RESET_VAL at once, and the next edge after release resumes counting from RESET_VAL.
